// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the register-file
// write-port arbiter.
`timescale 1ns/1ps
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // Game I/O mailbox registers that external requesters may write
    localparam int PROT_LO_DEF = 20;
    localparam int PROT_HI_DEF = 27;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    // True when the register address lies inside [lo, hi]
    function automatic logic in_prot_range(input logic [REG_ADDR_W-1:0] r,
                                           input int lo,
                                           input int hi);
        return (int'(r) >= lo) && (int'(r) <= hi);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Combinational round-robin pick: the first set request at or after ptr
// (wrapping) wins. Produces a one-hot grant plus its encoded index.
`timescale 1ns/1ps
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          valid
);

    // Scan from the farthest offset back to ptr so the nearest request wins
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % N;
            if (req[c]) begin
                idx   = PW'(c);
                valid = 1'b1;
            end
        end
        grant[idx] = valid;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: processor writeback has priority and
// passes through with zero latency; external game I/O requesters are served
// round-robin in idle writeback cycles, with a starvation counter that forces
// a one-cycle processor stall so external writes always complete.
// Optional build macro: REGARB_PROTECT_EN restricts external writes to
// registers PROT_LO..PROT_HI (out-of-range writes are acked, dropped, and
// flagged on prot_err).
`timescale 1ns/1ps
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_EXT      = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int PROT_LO      = PROT_LO_DEF,
    parameter int PROT_HI      = PROT_HI_DEF
) (
    input  logic                          clock,
    input  logic                          ctrl_reset_n,
    input  logic                          proc_we,
    input  logic [REG_ADDR_W-1:0]         proc_reg,
    input  logic [DATA_W-1:0]             proc_data,
    input  logic [NUM_EXT-1:0]            ext_req,
    input  logic [REG_ADDR_W*NUM_EXT-1:0] ext_reg,
    input  logic [DATA_W*NUM_EXT-1:0]     ext_data,
    output logic [NUM_EXT-1:0]            ext_ack,
    output logic                          ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0]         ctrl_writeReg,
    output logic [DATA_W-1:0]             data_writeReg,
    output logic                          stall_proc,
    output logic                          prot_err
);

    localparam int PW = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1;

`ifdef REGARB_PROTECT_EN
    localparam bit PROT_CHECK = 1'b1;
`else
    localparam bit PROT_CHECK = 1'b0;
`endif

    arb_state_t          state_reg;
    logic [PW-1:0]       rr_ptr_reg;
    logic [7:0]          starve_cnt_reg;

    logic [REG_ADDR_W-1:0] ext_reg_arr  [NUM_EXT];
    logic [DATA_W-1:0]     ext_data_arr [NUM_EXT];

    logic [NUM_EXT-1:0]    win_grant;
    logic [PW-1:0]         win_idx;
    logic                  win_valid;
    logic                  grant_ok;
    logic                  win_in_range;
    logic                  win_allowed;
    logic [REG_ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0]     win_data;
    logic [PW-1:0]         rr_ptr_next;
    logic                  any_req;

    // Unpack the per-requester register/data buses
    genvar gi;
    generate
        for (gi = 0; gi < NUM_EXT; gi++) begin : g_unpack
            assign ext_reg_arr[gi]  = ext_reg[REG_ADDR_W*gi +: REG_ADDR_W];
            assign ext_data_arr[gi] = ext_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    rr_arbiter_n #(
        .N  (NUM_EXT),
        .PW (PW)
    ) u_rr (
        .req   (ext_req),
        .ptr   (rr_ptr_reg),
        .grant (win_grant),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign any_req  = |ext_req;
    assign win_reg  = ext_reg_arr[win_idx];
    assign win_data = ext_data_arr[win_idx];

    // An external requester wins the port when the processor is idle or
    // the processor is being held off by a forced slot
    assign grant_ok = win_valid && ((state_reg == FORCE) || !proc_we);

    assign win_in_range = in_prot_range(win_reg, PROT_LO, PROT_HI);
    assign win_allowed  = !PROT_CHECK || win_in_range;

    assign rr_ptr_next = (win_idx == PW'(NUM_EXT - 1)) ? '0 : win_idx + 1'b1;

    // Write-port mux; everything is held at zero while reset is asserted
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ext_ack          = '0;
        prot_err         = 1'b0;
        if (ctrl_reset_n) begin
            if ((state_reg == NORMAL) && proc_we) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = proc_reg;
                data_writeReg    = proc_data;
            end else if (grant_ok) begin
                ext_ack          = win_grant;
                ctrl_writeEnable = win_allowed;
                ctrl_writeReg    = win_reg;
                data_writeReg    = win_data;
                prot_err         = PROT_CHECK && !win_in_range;
            end
        end
    end

    // Arbitration state: forced-slot FSM, round-robin pointer, starvation counter
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_reg      <= NORMAL;
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
            stall_proc     <= 1'b0;
        end else begin
            case (state_reg)
                NORMAL: begin
                    if (grant_ok) begin
                        rr_ptr_reg     <= rr_ptr_next;
                        starve_cnt_reg <= '0;
                    end else if (any_req) begin
                        if (starve_cnt_reg == 8'(STARVE_LIMIT - 1)) begin
                            state_reg      <= FORCE;
                            stall_proc     <= 1'b1;
                            starve_cnt_reg <= '0;
                        end else begin
                            starve_cnt_reg <= starve_cnt_reg + 8'd1;
                        end
                    end else begin
                        starve_cnt_reg <= '0;
                    end
                end
                FORCE: begin
                    // A withdrawn request simply leaves the port idle here
                    if (grant_ok) begin
                        rr_ptr_reg <= rr_ptr_next;
                    end
                    starve_cnt_reg <= '0;
                    stall_proc     <= 1'b0;
                    state_reg      <= NORMAL;
                end
                default: begin
                    state_reg <= NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter (NUM_EXT=4,
// STARVE_LIMIT=8). Requester k writes register 20+k with data 0xA000_000k.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    logic         clock;
    logic         ctrl_reset_n;
    logic         proc_we;
    logic [4:0]   proc_reg;
    logic [31:0]  proc_data;
    logic [3:0]   ext_req;
    logic [19:0]  ext_reg;
    logic [127:0] ext_data;
    logic [3:0]   ext_ack;
    logic         ctrl_writeEnable;
    logic [4:0]   ctrl_writeReg;
    logic [31:0]  data_writeReg;
    logic         stall_proc;
    logic         prot_err;

    int n_cmp;
    int n_bad;

    regfile_write_arbiter #(
        .NUM_EXT      (4),
        .STARVE_LIMIT (8),
        .PROT_LO      (20),
        .PROT_HI      (27)
    ) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .proc_we          (proc_we),
        .proc_reg         (proc_reg),
        .proc_data        (proc_data),
        .ext_req          (ext_req),
        .ext_reg          (ext_reg),
        .ext_data         (ext_data),
        .ext_ack          (ext_ack),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .stall_proc       (stall_proc),
        .prot_err         (prot_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        pwe;
        logic [4:0]  preg;
        logic [31:0] pdata;
        logic [3:0]  req;
        logic        exp_we;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic [3:0]  exp_ack;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] r,
                              input logic [31:0] d, input logic [3:0] ack, input logic st);
        check({tag, ".we"},    32'(ctrl_writeEnable), 32'(we));
        check({tag, ".reg"},   32'(ctrl_writeReg),    32'(r));
        check({tag, ".data"},  data_writeReg,         d);
        check({tag, ".ack"},   32'(ext_ack),          32'(ack));
        check({tag, ".stall"}, 32'(stall_proc),       32'(st));
        $display("%s: we=%0b reg=%0d data=0x%08h ack=%04b stall=%0b prot=%0b",
                 tag, ctrl_writeEnable, ctrl_writeReg, data_writeReg, ext_ack, stall_proc, prot_err);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //        pwe  preg   pdata          req      we  reg   data           ack
        vecs[0]  = '{1'b1, 5'd10, 32'h0000_00FF, 4'b0000, 1'b1, 5'd10, 32'h0000_00FF, 4'b0000};
        vecs[1]  = '{1'b0, 5'd10, 32'h0000_00FF, 4'b0000, 1'b0, 5'd0,  32'h0,          4'b0000};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         4'b1010, 1'b1, 5'd21, 32'hA000_0001, 4'b0010};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         4'b1010, 1'b1, 5'd23, 32'hA000_0003, 4'b1000};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         4'b1010, 1'b1, 5'd21, 32'hA000_0001, 4'b0010};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         4'b1010, 1'b1, 5'd23, 32'hA000_0003, 4'b1000};
        vecs[6]  = '{1'b1, 5'd0,  32'h1234_5678, 4'b0001, 1'b1, 5'd0,  32'h1234_5678, 4'b0000};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         4'b0001, 1'b1, 5'd20, 32'hA000_0000, 4'b0001};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         4'b1111, 1'b1, 5'd21, 32'hA000_0001, 4'b0010};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         4'b1111, 1'b1, 5'd22, 32'hA000_0002, 4'b0100};
        vecs[10] = '{1'b0, 5'd0,  32'h0,         4'b1111, 1'b1, 5'd23, 32'hA000_0003, 4'b1000};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         4'b1111, 1'b1, 5'd20, 32'hA000_0000, 4'b0001};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         4'b0001, 1'b1, 5'd20, 32'hA000_0000, 4'b0001};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         4'b0000, 1'b0, 5'd0,  32'h0,          4'b0000};

        ext_reg  = {5'd23, 5'd22, 5'd21, 5'd20};
        ext_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

        // Reset with everything requesting: outputs must be held at zero
        ctrl_reset_n = 1'b0;
        proc_we      = 1'b1;
        proc_reg     = 5'd10;
        proc_data    = 32'h0000_00FF;
        ext_req      = 4'b1111;
        #12;
        check_port("reset", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0);
        check("reset.prot", 32'(prot_err), 32'h0);

        // First cycle after release: processor write passes, no ack
        next_cycle();
        ctrl_reset_n = 1'b1;
        sample_point();
        check_port("post_reset", 1'b1, 5'd10, 32'h0000_00FF, 4'b0000, 1'b0);
        next_cycle();

        // Table of single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            proc_we   = vecs[i].pwe;
            proc_reg  = vecs[i].preg;
            proc_data = vecs[i].pdata;
            ext_req   = vecs[i].req;
            sample_point();
            check_port($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_reg,
                       vecs[i].exp_data, vecs[i].exp_ack, 1'b0);
            check($sformatf("vec%0d.prot", i), 32'(prot_err), 32'h0);
            next_cycle();
        end

        // Starvation: processor writes every cycle, requester 2 waits 8 cycles
        for (int i = 1; i <= 8; i++) begin
            proc_we   = 1'b1;
            proc_reg  = 5'd7;
            proc_data = 32'(i);
            ext_req   = 4'b0100;
            sample_point();
            check_port($sformatf("starve%0d", i), 1'b1, 5'd7, 32'(i), 4'b0000, 1'b0);
            next_cycle();
        end
        sample_point();
        check_port("force", 1'b1, 5'd22, 32'hA000_0002, 4'b0100, 1'b1);
        next_cycle();
        ext_req   = 4'b0000;
        proc_data = 32'h0000_0055;
        sample_point();
        check_port("after_force", 1'b1, 5'd7, 32'h0000_0055, 4'b0000, 1'b0);
        next_cycle();

        // Reset asserted in the middle of a FORCE cycle
        for (int i = 1; i <= 8; i++) begin
            proc_we = 1'b1;
            ext_req = 4'b0100;
            next_cycle();
        end
        check("force2.stall", 32'(stall_proc), 32'h1);
        ctrl_reset_n = 1'b0;
        #1;
        check_port("force_rst", 1'b0, 5'd0, 32'h0, 4'b0000, 1'b0);
        next_cycle();
        ctrl_reset_n = 1'b1;
        proc_we   = 1'b1;
        proc_reg  = 5'd9;
        proc_data = 32'h0000_0099;
        ext_req   = 4'b0000;
        sample_point();
        check_port("rst_normal", 1'b1, 5'd9, 32'h0000_0099, 4'b0000, 1'b0);
        next_cycle();
        proc_we = 1'b0;
        ext_req = 4'b1010;
        sample_point();
        check_port("rst_ptr0", 1'b1, 5'd21, 32'hA000_0001, 4'b0010, 1'b0);
        next_cycle();

        // External write to a register outside the mailbox range
        ext_reg = {5'd23, 5'd22, 5'd21, 5'd5};
        ext_req = 4'b0001;
        sample_point();
`ifdef REGARB_PROTECT_EN
        check_port("prot", 1'b0, 5'd5, 32'hA000_0000, 4'b0001, 1'b0);
        check("prot.err", 32'(prot_err), 32'h1);
`else
        check_port("prot", 1'b1, 5'd5, 32'hA000_0000, 4'b0001, 1'b0);
        check("prot.err", 32'(prot_err), 32'h0);
`endif
        next_cycle();
        ext_req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
